// File: rtl/id_ex_register.sv
// ---------------------------------------------------------------------------
// id_ex_register
//
// Purpose:
//   ID/EX pipeline register for the five-stage MIPS pipeline. It also detects
//   load-use hazards. Each rising edge it does one of three things:
//   - captures the decoded operands and control coming from ID;
//   - loads a bubble when EX resolves a taken branch or jump (Flush_EX);
//   - loads a bubble when the ID instruction needs the result of a load that
//     is still in EX (Stall).
//   Only the load-use bubbles are counted, in a saturating counter.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   *_ID                 decoded instruction fields and control from ID
//   UsesRt_ID            the ID instruction reads rt as a source
//   Flush_EX             kill the ID instruction (taken branch/jump in EX)
//   *_EX                 registered copies presented to EX and forwarding
//   Stall                combinational; freezes PC and IF/ID this cycle
//   StallCount           saturating count of load-use bubbles since reset
// ---------------------------------------------------------------------------
module id_ex_register #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC_plus4_ID,
    input  logic [4:0]       RsAddr_ID,
    input  logic [4:0]       RtAddr_ID,
    input  logic [4:0]       RdAddr_ID,
    input  logic [31:0]      RsData_ID,
    input  logic [31:0]      RtData_ID,
    input  logic [31:0]      Imm_ID,
    input  logic [4:0]       Shamt_ID,
    input  logic [5:0]       ALUFun_ID,
    input  logic             ALUSrc1_ID,
    input  logic             ALUSrc2_ID,
    input  logic [1:0]       RegDst_ID,
    input  logic             MemRead_ID,
    input  logic             MemWrite_ID,
    input  logic             RegWrite_ID,
    input  logic [1:0]       MemToReg_ID,
    input  logic             UsesRt_ID,
    input  logic             Flush_EX,
    output logic [31:0]      PC_plus4_EX,
    output logic [31:0]      RsData_EX,
    output logic [31:0]      RtData_EX,
    output logic [31:0]      Imm_EX,
    output logic [4:0]       RsAddr_EX,
    output logic [4:0]       RtAddr_EX,
    output logic [4:0]       RegWrAddr_EX,
    output logic [4:0]       Shamt_EX,
    output logic [5:0]       ALUFun_EX,
    output logic             ALUSrc1_EX,
    output logic             ALUSrc2_EX,
    output logic             MemRead_EX,
    output logic             MemWrite_EX,
    output logic             RegWrite_EX,
    output logic [1:0]       MemToReg_EX,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCount
);

    logic [31:0]      pc_plus4_q,    pc_plus4_d;
    logic [31:0]      rs_data_q,     rs_data_d;
    logic [31:0]      rt_data_q,     rt_data_d;
    logic [31:0]      imm_q,         imm_d;
    logic [4:0]       rs_addr_q,     rs_addr_d;
    logic [4:0]       rt_addr_q,     rt_addr_d;
    logic [4:0]       reg_wr_addr_q, reg_wr_addr_d;
    logic [4:0]       shamt_q,       shamt_d;
    logic [5:0]       alu_fun_q,     alu_fun_d;
    logic             alu_src1_q,    alu_src1_d;
    logic             alu_src2_q,    alu_src2_d;
    logic             mem_read_q,    mem_read_d;
    logic             mem_write_q,   mem_write_d;
    logic             reg_write_q,   reg_write_d;
    logic [1:0]       mem_to_reg_q,  mem_to_reg_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [4:0]       dest_addr;
    logic             load_hit;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. rt only counts when ID really reads it, because many I-type
    // instructions write rt. A load to $zero never writes anything, so it
    // cannot create a dependency. A flush kills the ID instruction, so no
    // stall is needed in that cycle.
    always_comb begin
        load_hit = (rt_addr_q == RsAddr_ID)
                 | (UsesRt_ID & (rt_addr_q == RtAddr_ID));
        Stall    = mem_read_q & (rt_addr_q != 5'd0) & load_hit & ~Flush_EX;
    end

    // Work out the write-back register at capture time, so the forwarding
    // unit sees the real destination. The reserved encoding 11 selects Rd.
    always_comb begin
        case (RegDst_ID)
            2'b01:   dest_addr = RtAddr_ID;
            2'b10:   dest_addr = 5'd31;
            default: dest_addr = RdAddr_ID;
        endcase
    end

    // Next-state selection. Every field defaults to a bubble (all zero), so a
    // flushed or stalled slot has no write enable and no address that
    // forwarding could match. Only a load-use bubble advances the counter,
    // and the counter stops at its all-ones value.
    always_comb begin
        pc_plus4_d    = '0;
        rs_data_d     = '0;
        rt_data_d     = '0;
        imm_d         = '0;
        rs_addr_d     = '0;
        rt_addr_d     = '0;
        reg_wr_addr_d = '0;
        shamt_d       = '0;
        alu_fun_d     = '0;
        alu_src1_d    = 1'b0;
        alu_src2_d    = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        reg_write_d   = 1'b0;
        mem_to_reg_d  = '0;
        stall_count_d = stall_count_q;

        if (!Flush_EX) begin
            if (Stall) begin
                if (stall_count_q != {CNT_W{1'b1}}) begin
                    stall_count_d = stall_count_q + CNT_W'(1);
                end
            end else begin
                pc_plus4_d    = PC_plus4_ID;
                rs_data_d     = RsData_ID;
                rt_data_d     = RtData_ID;
                imm_d         = Imm_ID;
                rs_addr_d     = RsAddr_ID;
                rt_addr_d     = RtAddr_ID;
                reg_wr_addr_d = dest_addr;
                shamt_d       = Shamt_ID;
                alu_fun_d     = ALUFun_ID;
                alu_src1_d    = ALUSrc1_ID;
                alu_src2_d    = ALUSrc2_ID;
                mem_read_d    = MemRead_ID;
                mem_write_d   = MemWrite_ID;
                reg_write_d   = RegWrite_ID;
                mem_to_reg_d  = MemToReg_ID;
            end
        end
    end

    // Pipeline and counter flops. Reset has priority over everything and
    // clears the counter as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_plus4_q    <= '0;
            rs_data_q     <= '0;
            rt_data_q     <= '0;
            imm_q         <= '0;
            rs_addr_q     <= '0;
            rt_addr_q     <= '0;
            reg_wr_addr_q <= '0;
            shamt_q       <= '0;
            alu_fun_q     <= '0;
            alu_src1_q    <= 1'b0;
            alu_src2_q    <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= '0;
            stall_count_q <= '0;
        end else begin
            pc_plus4_q    <= pc_plus4_d;
            rs_data_q     <= rs_data_d;
            rt_data_q     <= rt_data_d;
            imm_q         <= imm_d;
            rs_addr_q     <= rs_addr_d;
            rt_addr_q     <= rt_addr_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            shamt_q       <= shamt_d;
            alu_fun_q     <= alu_fun_d;
            alu_src1_q    <= alu_src1_d;
            alu_src2_q    <= alu_src2_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign PC_plus4_EX  = pc_plus4_q;
    assign RsData_EX    = rs_data_q;
    assign RtData_EX    = rt_data_q;
    assign Imm_EX       = imm_q;
    assign RsAddr_EX    = rs_addr_q;
    assign RtAddr_EX    = rt_addr_q;
    assign RegWrAddr_EX = reg_wr_addr_q;
    assign Shamt_EX     = shamt_q;
    assign ALUFun_EX    = alu_fun_q;
    assign ALUSrc1_EX   = alu_src1_q;
    assign ALUSrc2_EX   = alu_src2_q;
    assign MemRead_EX   = mem_read_q;
    assign MemWrite_EX  = mem_write_q;
    assign RegWrite_EX  = reg_write_q;
    assign MemToReg_EX  = mem_to_reg_q;
    assign StallCount   = stall_count_q;

endmodule

// File: tb/tb_id_ex_register.sv
// ---------------------------------------------------------------------------
// tb_id_ex_register
//
// Purpose:
//   Self-checking bench for id_ex_register. Two instances share all inputs:
//   one with the default 32-bit counter, and one with a 4-bit counter to
//   exercise saturation. Each table row lists the ID fields, the hand-derived
//   Stall value, the expected destination register and the expected stall
//   count. At drive time the row is turned into an expected EX record and
//   pushed to a scoreboard queue. After the edge the record is popped and
//   compared with both instances.
// ---------------------------------------------------------------------------
module tb_id_ex_register;

    logic        clk;
    logic        reset;
    logic [31:0] PC_plus4_ID, RsData_ID, RtData_ID, Imm_ID;
    logic [4:0]  RsAddr_ID, RtAddr_ID, RdAddr_ID, Shamt_ID;
    logic [5:0]  ALUFun_ID;
    logic        ALUSrc1_ID, ALUSrc2_ID, MemRead_ID, MemWrite_ID, RegWrite_ID;
    logic [1:0]  RegDst_ID, MemToReg_ID;
    logic        UsesRt_ID, Flush_EX;

    logic [31:0] PC_plus4_EX, RsData_EX, RtData_EX, Imm_EX;
    logic [4:0]  RsAddr_EX, RtAddr_EX, RegWrAddr_EX, Shamt_EX;
    logic [5:0]  ALUFun_EX;
    logic        ALUSrc1_EX, ALUSrc2_EX, MemRead_EX, MemWrite_EX, RegWrite_EX;
    logic [1:0]  MemToReg_EX;
    logic        Stall;
    logic [31:0] StallCount;

    logic [31:0] s_PC_plus4_EX, s_RsData_EX, s_RtData_EX, s_Imm_EX;
    logic [4:0]  s_RsAddr_EX, s_RtAddr_EX, s_RegWrAddr_EX, s_Shamt_EX;
    logic [5:0]  s_ALUFun_EX;
    logic        s_ALUSrc1_EX, s_ALUSrc2_EX, s_MemRead_EX, s_MemWrite_EX, s_RegWrite_EX;
    logic [1:0]  s_MemToReg_EX;
    logic        s_Stall;
    logic [3:0]  s_StallCount;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  wr_addr;
        logic [4:0]  shamt;
        logic [5:0]  alu_fun;
        logic        alu_src1;
        logic        alu_src2;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  mem_to_reg;
    } ex_t;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [1:0]  reg_dst;
        logic        mr, mw, rw, uses_rt, flush;
        logic [31:0] imm;
        logic        exp_stall;
        logic [4:0]  exp_waddr;
        int          exp_cnt;
    } vec_t;

    typedef struct {
        ex_t ex;
        int  cnt;
    } sb_t;

    ex_t  dut_ex, small_ex;
    sb_t  sb_q[$];
    vec_t vecs[20];
    int   total;
    int   bad;

    // Pack the EX outputs of both instances in the same field order as ex_t.
    assign dut_ex = {PC_plus4_EX, RsData_EX, RtData_EX, Imm_EX, RsAddr_EX,
                     RtAddr_EX, RegWrAddr_EX, Shamt_EX, ALUFun_EX, ALUSrc1_EX,
                     ALUSrc2_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, MemToReg_EX};
    assign small_ex = {s_PC_plus4_EX, s_RsData_EX, s_RtData_EX, s_Imm_EX, s_RsAddr_EX,
                       s_RtAddr_EX, s_RegWrAddr_EX, s_Shamt_EX, s_ALUFun_EX, s_ALUSrc1_EX,
                       s_ALUSrc2_EX, s_MemRead_EX, s_MemWrite_EX, s_RegWrite_EX, s_MemToReg_EX};

    id_ex_register dut (
        .clk(clk), .reset(reset),
        .PC_plus4_ID(PC_plus4_ID), .RsAddr_ID(RsAddr_ID), .RtAddr_ID(RtAddr_ID),
        .RdAddr_ID(RdAddr_ID), .RsData_ID(RsData_ID), .RtData_ID(RtData_ID),
        .Imm_ID(Imm_ID), .Shamt_ID(Shamt_ID), .ALUFun_ID(ALUFun_ID),
        .ALUSrc1_ID(ALUSrc1_ID), .ALUSrc2_ID(ALUSrc2_ID), .RegDst_ID(RegDst_ID),
        .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegWrite_ID(RegWrite_ID),
        .MemToReg_ID(MemToReg_ID), .UsesRt_ID(UsesRt_ID), .Flush_EX(Flush_EX),
        .PC_plus4_EX(PC_plus4_EX), .RsData_EX(RsData_EX), .RtData_EX(RtData_EX),
        .Imm_EX(Imm_EX), .RsAddr_EX(RsAddr_EX), .RtAddr_EX(RtAddr_EX),
        .RegWrAddr_EX(RegWrAddr_EX), .Shamt_EX(Shamt_EX), .ALUFun_EX(ALUFun_EX),
        .ALUSrc1_EX(ALUSrc1_EX), .ALUSrc2_EX(ALUSrc2_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .RegWrite_EX(RegWrite_EX), .MemToReg_EX(MemToReg_EX),
        .Stall(Stall), .StallCount(StallCount)
    );

    id_ex_register #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset),
        .PC_plus4_ID(PC_plus4_ID), .RsAddr_ID(RsAddr_ID), .RtAddr_ID(RtAddr_ID),
        .RdAddr_ID(RdAddr_ID), .RsData_ID(RsData_ID), .RtData_ID(RtData_ID),
        .Imm_ID(Imm_ID), .Shamt_ID(Shamt_ID), .ALUFun_ID(ALUFun_ID),
        .ALUSrc1_ID(ALUSrc1_ID), .ALUSrc2_ID(ALUSrc2_ID), .RegDst_ID(RegDst_ID),
        .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID), .RegWrite_ID(RegWrite_ID),
        .MemToReg_ID(MemToReg_ID), .UsesRt_ID(UsesRt_ID), .Flush_EX(Flush_EX),
        .PC_plus4_EX(s_PC_plus4_EX), .RsData_EX(s_RsData_EX), .RtData_EX(s_RtData_EX),
        .Imm_EX(s_Imm_EX), .RsAddr_EX(s_RsAddr_EX), .RtAddr_EX(s_RtAddr_EX),
        .RegWrAddr_EX(s_RegWrAddr_EX), .Shamt_EX(s_Shamt_EX), .ALUFun_EX(s_ALUFun_EX),
        .ALUSrc1_EX(s_ALUSrc1_EX), .ALUSrc2_EX(s_ALUSrc2_EX), .MemRead_EX(s_MemRead_EX),
        .MemWrite_EX(s_MemWrite_EX), .RegWrite_EX(s_RegWrite_EX), .MemToReg_EX(s_MemToReg_EX),
        .Stall(s_Stall), .StallCount(s_StallCount)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends, even if the sequence stops moving.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [1:0] reg_dst,
                                   input logic mr, input logic mw, input logic rw,
                                   input logic uses_rt, input logic flush,
                                   input logic [31:0] imm, input logic exp_stall,
                                   input logic [4:0] exp_waddr, input int exp_cnt);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.reg_dst = reg_dst;
        v.mr = mr; v.mw = mw; v.rw = rw; v.uses_rt = uses_rt; v.flush = flush;
        v.imm = imm; v.exp_stall = exp_stall; v.exp_waddr = exp_waddr; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0b, want %0b", name, act, req);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic checkEx(input string name, input ex_t act, input ex_t req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Drive one ID instruction at the falling edge, check the combinational
    // Stall before the rising edge, and queue what EX should hold afterwards.
    // Data fields are derived from idx so every captured record is distinct.
    task automatic applyStimulus(input vec_t v, input int idx);
        sb_t e;
        @(negedge clk);
        PC_plus4_ID = 32'h0040_0000 + 32'(idx * 4);
        RsData_ID   = 32'hA000_0000 | 32'(idx);
        RtData_ID   = 32'hB000_0000 | 32'(idx);
        Imm_ID      = v.imm;
        RsAddr_ID   = v.rs;
        RtAddr_ID   = v.rt;
        RdAddr_ID   = v.rd;
        Shamt_ID    = 5'(idx);
        ALUFun_ID   = 6'(idx) ^ 6'h2A;
        ALUSrc1_ID  = idx[0];
        ALUSrc2_ID  = idx[1];
        RegDst_ID   = v.reg_dst;
        MemRead_ID  = v.mr;
        MemWrite_ID = v.mw;
        RegWrite_ID = v.rw;
        MemToReg_ID = v.mr ? 2'b01 : 2'b00;
        UsesRt_ID   = v.uses_rt;
        Flush_EX    = v.flush;
        #1;
        checkBit($sformatf("stall[%0d]", idx), Stall, v.exp_stall);
        checkBit($sformatf("stall_small[%0d]", idx), s_Stall, v.exp_stall);
        if (v.flush || v.exp_stall) begin
            e.ex = '0;
        end else begin
            e.ex = {PC_plus4_ID, RsData_ID, RtData_ID, v.imm, v.rs, v.rt, v.exp_waddr,
                    Shamt_ID, ALUFun_ID, ALUSrc1_ID, ALUSrc2_ID, v.mr, v.mw, v.rw,
                    MemToReg_ID};
        end
        e.cnt = v.exp_cnt;
        sb_q.push_back(e);
    endtask

    // After the rising edge, pop the oldest expectation and compare it with
    // both instances. The 4-bit counter must saturate at 15.
    task automatic checkOutput(input int idx);
        sb_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard[%0d]: got empty queue, want one entry", idx);
        end else begin
            e = sb_q.pop_front();
            checkEx($sformatf("ex[%0d]", idx), dut_ex, e.ex);
            checkEx($sformatf("ex_small[%0d]", idx), small_ex, e.ex);
            checkInt($sformatf("count[%0d]", idx), int'(StallCount), e.cnt);
            checkInt($sformatf("count_small[%0d]", idx), int'(s_StallCount),
                     (e.cnt > 15) ? 15 : e.cnt);
        end
    endtask

    initial begin
        int cnt;
        total = 0;
        bad   = 0;

        // Row order: rs rt rd regdst mr mw rw usesRt flush imm | stall waddr count
        vecs[0]  = mkVec(5'd3,  5'd4,  5'd5,  2'b00, 0, 0, 1, 1, 0, 32'h1234, 0, 5'd5,  0);
        vecs[1]  = mkVec(5'd3,  5'd4,  5'd5,  2'b10, 0, 0, 1, 1, 0, 32'h1234, 0, 5'd31, 0);
        vecs[2]  = mkVec(5'd1,  5'd8,  5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0010, 0, 5'd8,  0);
        vecs[3]  = mkVec(5'd8,  5'd2,  5'd10, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 1, 5'd0,  1);
        vecs[4]  = mkVec(5'd8,  5'd2,  5'd10, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 0, 5'd10, 1);
        vecs[5]  = mkVec(5'd1,  5'd9,  5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0020, 0, 5'd9,  1);
        vecs[6]  = mkVec(5'd2,  5'd9,  5'd11, 2'b00, 0, 0, 1, 0, 0, 32'h0000, 0, 5'd11, 1);
        vecs[7]  = mkVec(5'd3,  5'd9,  5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0024, 0, 5'd9,  1);
        vecs[8]  = mkVec(5'd2,  5'd9,  5'd11, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 1, 5'd0,  2);
        vecs[9]  = mkVec(5'd2,  5'd9,  5'd11, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 0, 5'd11, 2);
        vecs[10] = mkVec(5'd1,  5'd0,  5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0030, 0, 5'd0,  2);
        vecs[11] = mkVec(5'd0,  5'd0,  5'd12, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 0, 5'd12, 2);
        vecs[12] = mkVec(5'd1,  5'd5,  5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0040, 0, 5'd5,  2);
        vecs[13] = mkVec(5'd5,  5'd6,  5'd7,  2'b00, 0, 0, 1, 1, 1, 32'h0000, 0, 5'd0,  2);
        vecs[14] = mkVec(5'd1,  5'd10, 5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0050, 0, 5'd10, 2);
        vecs[15] = mkVec(5'd10, 5'd11, 5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0054, 1, 5'd0,  3);
        vecs[16] = mkVec(5'd10, 5'd11, 5'd0,  2'b01, 1, 0, 1, 0, 0, 32'h0054, 0, 5'd11, 3);
        vecs[17] = mkVec(5'd4,  5'd11, 5'd13, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 1, 5'd0,  4);
        vecs[18] = mkVec(5'd4,  5'd11, 5'd13, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 0, 5'd13, 4);
        vecs[19] = mkVec(5'd1,  5'd13, 5'd0,  2'b00, 0, 1, 0, 1, 0, 32'h0008, 0, 5'd0,  4);

        // Reset for two edges with junk on the ID side.
        reset = 1'b1;
        PC_plus4_ID = 32'hDEAD_BEEF; RsData_ID = 32'h1111_1111; RtData_ID = 32'h2222_2222;
        Imm_ID = 32'hFFFF_FFFF; RsAddr_ID = 5'd7; RtAddr_ID = 5'd7; RdAddr_ID = 5'd9;
        Shamt_ID = 5'd3; ALUFun_ID = 6'h15; ALUSrc1_ID = 1'b1; ALUSrc2_ID = 1'b1;
        RegDst_ID = 2'b01; MemRead_ID = 1'b1; MemWrite_ID = 1'b1; RegWrite_ID = 1'b1;
        MemToReg_ID = 2'b01; UsesRt_ID = 1'b1; Flush_EX = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkEx("reset_ex", dut_ex, '0);
        checkBit("reset_stall", Stall, 1'b0);
        checkInt("reset_count", int'(StallCount), 0);
        checkInt("reset_count_small", int'(s_StallCount), 0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven section.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i], i);
            checkOutput(i);
        end

        // Reset while a load-use stall is pending: the edge clears everything,
        // and Stall is low in the following cycle.
        applyStimulus(mkVec(5'd1, 5'd8, 5'd0, 2'b01, 1, 0, 1, 0, 0, 32'h0060, 0, 5'd8, 4), 20);
        checkOutput(20);
        @(negedge clk);
        RsAddr_ID = 5'd8; RtAddr_ID = 5'd2; RdAddr_ID = 5'd14; RegDst_ID = 2'b00;
        MemRead_ID = 1'b0; MemWrite_ID = 1'b0; UsesRt_ID = 1'b1;
        reset = 1'b1;
        #1;
        checkBit("midstall_stall_before", Stall, 1'b1);
        @(posedge clk);
        #1;
        checkEx("midstall_ex", dut_ex, '0);
        checkInt("midstall_count", int'(StallCount), 0);
        checkInt("midstall_count_small", int'(s_StallCount), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkBit("midstall_stall_after", Stall, 1'b0);

        // Twenty load-use pairs. The 4-bit instance must stop at 15 and hold.
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(mkVec(5'd1, 5'd8, 5'd0, 2'b01, 1, 0, 1, 0, 0, 32'h0100, 0, 5'd8, cnt),
                          30 + 2 * k);
            checkOutput(30 + 2 * k);
            cnt++;
            applyStimulus(mkVec(5'd8, 5'd3, 5'd15, 2'b00, 0, 0, 1, 1, 0, 32'h0000, 1, 5'd0, cnt),
                          31 + 2 * k);
            checkOutput(31 + 2 * k);
        end
        checkInt("sat_final_small", int'(s_StallCount), 15);
        checkInt("sat_final", int'(StallCount), 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
